// File: rtl/somador_serial.sv
// Serial adder/subtractor: sums STEP bits per clock, producing a WIDTH+1 bit result
// with carry out and signed overflow after WIDTH/STEP+1 cycles.
module somador_serial #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   s,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / STEP;
  localparam int CW     = $clog2(NSLICE + 1);
  localparam logic [CW-1:0] LAST  = CW'(NSLICE - 1);
  localparam logic [CW-1:0] DRAIN = CW'(NSLICE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             sub_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH:0]   s_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;

  int               pos_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [STEP-1:0]  a_sl_s;
  logic [STEP-1:0]  b_sl_s;
  logic [STEP:0]    sum_s;
  logic             cmsb_s;

  // Slice adder for the slice selected by the step counter
  always_comb begin
    pos_s   = int'(cnt_r) * STEP;
    b_eff_s = sub_r ? ~b_r : b_r;
    a_sl_s  = a_r[pos_s +: STEP];
    b_sl_s  = b_eff_s[pos_s +: STEP];
    sum_s   = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{STEP{1'b0}}, carry_r};
    // carry into the top bit of the slice, recovered from its sum bit
    cmsb_s  = a_sl_s[STEP-1] ^ b_sl_s[STEP-1] ^ sum_s[STEP-1];
  end

  // Control FSM, operand capture and result accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      sub_r   <= 1'b0;
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      s_r     <= {(WIDTH+1){1'b0}};
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            sub_r   <= sub;
            carry_r <= sub;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          // one commit cycle after the last slice sets the WIDTH/STEP+1 latency
          if (cnt_r == DRAIN) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            s_r[pos_s +: STEP] <= sum_s[STEP-1:0];
            carry_r            <= sum_s[STEP];
            cnt_r              <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_r == LAST) begin
              s_r[WIDTH] <= sum_s[STEP];
              ovf_r      <= cmsb_s ^ sum_s[STEP];
            end else begin
              ovf_r <= ovf_r;
            end
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign s    = s_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_somador_serial.sv
// Self-checking bench for somador_serial: directed sequence on an 8x1 instance plus
// a bank of WIDTH/STEP configurations driven in lockstep against a reference model.
module tb_somador_serial;

  localparam int NC = 11;
  localparam int GW [NC] = '{5, 5, 8, 8, 8, 8, 16, 16, 16, 16, 16};
  localparam int GS [NC] = '{1, 5, 1, 2, 4, 8, 1, 2, 4, 8, 16};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sub = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic busy, done, ovf;
  logic [8:0] s;

  logic gstart = 1'b0;
  logic gsub = 1'b0;
  logic [15:0] ga = 16'h0000;
  logic [15:0] gb = 16'h0000;
  logic [NC-1:0] gbusy;
  logic [32:0] gs_got [NC];
  logic go_got [NC];
  longint glat [NC];
  int gn [NC];

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int nops = 0;

  typedef struct {logic [32:0] s; logic ovf; int t;} exp_t;
  typedef struct {int idx; logic [32:0] s; logic ovf;} gexp_t;
  exp_t mq[$];
  gexp_t gq[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  somador_serial #(.WIDTH(8), .STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .s(s), .ovf(ovf)
  );

  for (genvar g = 0; g < NC; g++) begin : gen
    localparam int W = GW[g];
    localparam int S = GS[g];
    logic bsy, dn, ov;
    logic [W:0] sv;
    time t0 = 0;
    longint lat = 0;
    int n = 0;
    logic [32:0] cs = 33'd0;
    logic co = 1'b0;

    somador_serial #(.WIDTH(W), .STEP(S)) u (
      .clk(clk), .rst_n(rst_n), .start(gstart), .sub(gsub),
      .a(ga[W-1:0]), .b(gb[W-1:0]),
      .busy(bsy), .done(dn), .s(sv), .ovf(ov)
    );

    always @(posedge clk) if (gstart) t0 <= $time;

    always @(negedge clk) begin
      if (dn) begin
        n   <= n + 1;
        lat <= longint'($time - t0);
        cs  <= 33'(sv);
        co  <= ov;
      end
    end

    assign gbusy[g]  = bsy;
    assign gs_got[g] = cs;
    assign go_got[g] = co;
    assign glat[g]   = lat;
    assign gn[g]     = n;
  end

  // Arithmetic reference: unsigned add / subtract with no-borrow flag, signed overflow by range.
  function automatic void refm(input int w, input logic [31:0] x, input logic [31:0] y,
                               input logic m, output logic [32:0] rs, output logic ro);
    longint mask, ux, uy, half, sx, sy, r;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ux = longint'(x) & mask;
    uy = longint'(y) & mask;
    sx = (ux >= half) ? ux - 2 * half : ux;
    sy = (uy >= half) ? uy - 2 * half : uy;
    if (!m) begin
      rs = 33'(ux + uy);
      r  = sx + sy;
    end else begin
      rs = 33'((ux - uy) & mask);
      rs[w] = (ux >= uy);
      r  = sx - sy;
    end
    ro = (r >= half) || (r < -half);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [7:0] x, input logic [7:0] y, input logic m, input bit track);
    exp_t e;
    a = x; b = y; sub = m; start = 1'b1;
    if (track) begin
      refm(8, 32'(x), 32'(y), m, e.s, e.ovf);
      e.t = cyc + 1;
      mq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) chk({tag, "_timeout"}, 64'(done), 64'd1);
    else if (mq.size() == 0) chk({tag, "_unexpected_done"}, 64'(done), 64'd0);
    else begin
      e = mq.pop_front();
      chk({tag, "_s"}, 64'(s), 64'(e.s));
      chk({tag, "_ovf"}, 64'(ovf), 64'(e.ovf));
      chk({tag, "_latency"}, 64'(cyc - e.t), 64'd9);
      chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic gop(input logic [15:0] x, input logic [15:0] y, input logic m);
    gexp_t e;
    int n = 0;
    ga = x; gb = y; gsub = m; gstart = 1'b1;
    nops++;
    for (int i = 0; i < NC; i++) begin
      e.idx = i;
      refm(GW[i], 32'(x), 32'(y), m, e.s, e.ovf);
      gq.push_back(e);
    end
    @(negedge clk);
    gstart = 1'b0;
    while (gbusy != {NC{1'b0}} && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("gen_idle", 64'(gbusy), 64'd0);
    @(negedge clk);
    while (gq.size() > 0) begin
      e = gq.pop_front();
      chk($sformatf("w%0d_st%0d_s", GW[e.idx], GS[e.idx]), 64'(gs_got[e.idx]), 64'(e.s));
      chk($sformatf("w%0d_st%0d_ovf", GW[e.idx], GS[e.idx]), 64'(go_got[e.idx]), 64'(e.ovf));
      chk($sformatf("w%0d_st%0d_lat", GW[e.idx], GS[e.idx]), 64'(glat[e.idx]),
          64'((GW[e.idx] / GS[e.idx] + 1) * 10 + 5));
      chk($sformatf("w%0d_st%0d_ndone", GW[e.idx], GS[e.idx]), 64'(gn[e.idx]), 64'(nops));
    end
  endtask

  initial begin
    exp_t e;
    bit seen;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);

    // first start right at reset release; operands change right after capture
    rst_n = 1'b1;
    go(8'hFF, 8'h01, 1'b0, 1'b1);
    a = 8'h00; b = 8'h55; sub = 1'b1;
    wait_done("ff_plus_01");
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("s_hold_idle", 64'(s), 64'h100);
    chk("ovf_hold_idle", 64'(ovf), 64'd0);

    // start held high through RUN: new operands only taken in DONE
    a = 8'h3C; b = 8'h5A; sub = 1'b0; start = 1'b1;
    refm(8, 32'(8'h3C), 32'(8'h5A), 1'b0, e.s, e.ovf);
    e.t = cyc + 1;
    mq.push_back(e);
    @(negedge clk);
    a = 8'h80; b = 8'h01; sub = 1'b1;
    wait_done("held_first");
    refm(8, 32'(8'h80), 32'(8'h01), 1'b1, e.s, e.ovf);
    e.t = cyc + 1;
    mq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    a = 8'hAA; b = 8'hAA; sub = 1'b0;
    wait_done("held_second");
    chk("held_second_const", 64'(s), 64'h17F);
    @(negedge clk);

    // asynchronous reset in the middle of an operation
    go(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_s", 64'(s), 64'd0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("no_done_after_abort", 64'(seen), 64'd0);
    go(8'hC8, 8'h64, 1'b1, 1'b1);
    wait_done("post_reset");
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      go(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      wait_done($sformatf("main_rand%0d", i));
      @(negedge clk);
    end
    chk("main_queue_empty", 64'(mq.size()), 64'd0);

    // parameter bank: directed vectors then random regression
    gop(16'h007F, 16'h0001, 1'b0);
    chk("w8st2_7f_plus_1_s", 64'(gs_got[3]), 64'h080);
    chk("w8st2_7f_plus_1_ovf", 64'(go_got[3]), 64'd1);
    chk("w8st1_7f_plus_1_lat", 64'(glat[2]), 64'd95);
    gop(16'h0003, 16'h0005, 1'b1);
    chk("w8st4_3_minus_5_s", 64'(gs_got[4]), 64'h0FE);
    chk("w8st4_3_minus_5_ovf", 64'(go_got[4]), 64'd0);
    gop(16'h0080, 16'h0001, 1'b1);
    chk("w8st4_80_minus_1_s", 64'(gs_got[4]), 64'h17F);
    chk("w8st4_80_minus_1_ovf", 64'(go_got[4]), 64'd1);
    gop(16'hFFFF, 16'hFFFF, 1'b0);
    gop(16'h0000, 16'hFFFF, 1'b1);
    gop(16'h8000, 16'h8000, 1'b0);
    gop(16'h1234, 16'h1234, 1'b1);
    for (int i = 0; i < 30; i++) begin
      gop(16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
